// File: rtl/change_dispense_sched.sv
// change_dispense_sched: meters a change amount out as 2-unit then 1-unit hopper pulses,
// with idle gaps between pulses, hopper stock tracking and shortfall reporting.
module change_dispense_sched #(
    parameter int AMT_W      = 4,
    parameter int CNT_W      = 4,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_MAX  = 15,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic [AMT_W-1:0] req_amount_i,
    output logic             req_ready_o,
    input  logic             abort_i,
    input  logic             refill1_i,
    input  logic             refill2_i,
    output logic             out1_o,
    output logic             out2_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             short_o,
    output logic [AMT_W-1:0] remain_o,
    output logic [CNT_W-1:0] stock1_o,
    output logic [CNT_W-1:0] stock2_o
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] amt_q, amt_d, remain_q, remain_d;
    logic [CNT_W-1:0] stock1_q, stock1_d, stock2_q, stock2_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             coin2_q, coin2_d;
    logic             short_q, short_d, done_q, done_d;
    logic             out1_q, out1_d, out2_q, out2_d;

    always_comb begin
        state_d  = state_q;
        amt_d    = amt_q;
        coin2_d  = coin2_q;
        gap_d    = gap_q;
        short_d  = short_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                state_d  = SELECT;
                amt_d    = req_amount_i;
                short_d  = 1'b0;
                remain_d = '0;
            end
            SELECT: if (abort_i) begin
                state_d = DONE;
                short_d = 1'b1;
            end else if (amt_q == '0) begin
                state_d = DONE;
            end else if (amt_q >= AMT_W'(2) && stock2_q != '0) begin
                state_d = PULSE;
                coin2_d = 1'b1;
            end else if (stock1_q != '0) begin
                state_d = PULSE;
                coin2_d = 1'b0;
            end else begin
                state_d = DONE;
                short_d = 1'b1;
            end
            PULSE: begin
                amt_d   = amt_q - (coin2_q ? AMT_W'(2) : AMT_W'(1));
                gap_d   = '0;
                state_d = GAP_CYCLES == 0 ? SELECT : GAP;
            end
            GAP: if (abort_i) begin
                state_d = DONE;
                short_d = 1'b1;
            end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
                state_d = SELECT;
            end else begin
                gap_d = gap_q + GW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // DONE lasts one cycle, so this fires only on entry
        if (state_d == DONE) remain_d = amt_d;
        done_d   = state_d == DONE;
        out2_d   = state_d == PULSE && coin2_d;
        out1_d   = state_d == PULSE && !coin2_d;
        // refill and the pulse's decrement combine, so a refill during a pulse leaves MAX-1
        stock1_d = (refill1_i ? CNT_W'(STOCK_MAX) : stock1_q) - CNT_W'(out1_q);
        stock2_d = (refill2_i ? CNT_W'(STOCK_MAX) : stock2_q) - CNT_W'(out2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            amt_q    <= '0;
            coin2_q  <= 1'b0;
            gap_q    <= '0;
            short_q  <= 1'b0;
            remain_q <= '0;
            done_q   <= 1'b0;
            out1_q   <= 1'b0;
            out2_q   <= 1'b0;
            stock1_q <= CNT_W'(STOCK_INIT);
            stock2_q <= CNT_W'(STOCK_INIT);
        end else begin
            state_q  <= state_d;
            amt_q    <= amt_d;
            coin2_q  <= coin2_d;
            gap_q    <= gap_d;
            short_q  <= short_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            stock1_q <= stock1_d;
            stock2_q <= stock2_d;
        end
    end

    assign req_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign out1_o      = out1_q;
    assign out2_o      = out2_q;
    assign done_o      = done_q;
    assign short_o     = short_q;
    assign remain_o    = remain_q;
    assign stock1_o    = stock1_q;
    assign stock2_o    = stock2_q;
endmodule

// File: tb/tb_change_dispense_sched.sv
// tb_change_dispense_sched: directed jobs against a default instance and a low-stock
// instance; expected job results are queued at request time and checked at done.
module tb_change_dispense_sched;
    typedef struct {
        int done_at;
        int sh;
        int rem;
        int s1;
        int s2;
        int n2;
        int n1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid_i = 1'b0;
    logic [3:0] req_amount_i = '0;
    logic       abort_i = 1'b0;
    logic       refill1_i = 1'b0;
    logic       refill2_i = 1'b0;
    logic       v1 = 1'b0;
    logic       req_valid1;
    logic       req_ready_o, out1_o, out2_o, busy_o, done_o, short_o;
    logic [3:0] remain_o, stock1_o, stock2_o;
    logic       ready1, out1_1, out2_1, busy1, done1, short1;
    logic [3:0] remain1, stock1_1, stock2_1;

    int   cyc = 0;
    int   base = 0;
    int   passed = 0;
    int   total = 0;
    int   n2_0 = 0, n1_0 = 0, ndone0 = 0, n2_1 = 0, n1_1 = 0;
    int   p2_at[64];
    int   p1_at[64];
    int   d1_seen = 0, d1_at = 0, d1_sh = 0, d1_rem = 0, d1_s1 = 0, d1_s2 = 0;
    exp_t q0[$];
    exp_t q1[$];

    assign req_valid1 = req_valid_i & v1;

    change_dispense_sched dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_amount_i(req_amount_i),
        .req_ready_o(req_ready_o), .abort_i(abort_i), .refill1_i(refill1_i),
        .refill2_i(refill2_i), .out1_o(out1_o), .out2_o(out2_o), .busy_o(busy_o),
        .done_o(done_o), .short_o(short_o), .remain_o(remain_o),
        .stock1_o(stock1_o), .stock2_o(stock2_o)
    );

    change_dispense_sched #(.STOCK_INIT(1)) dut_low (
        .clk(clk), .rst(rst), .req_valid_i(req_valid1), .req_amount_i(req_amount_i),
        .req_ready_o(ready1), .abort_i(abort_i), .refill1_i(1'b0),
        .refill2_i(1'b0), .out1_o(out1_1), .out2_o(out2_1), .busy_o(busy1),
        .done_o(done1), .short_o(short1), .remain_o(remain1),
        .stock1_o(stock1_1), .stock2_o(stock2_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out2_o) begin p2_at[n2_0 % 64] = cyc - base; n2_0++; end
        if (out1_o) begin p1_at[n1_0 % 64] = cyc - base; n1_0++; end
        if (done_o) ndone0++;
        if (out2_1) n2_1++;
        if (out1_1) n1_1++;
        if (done1) begin
            d1_seen = 1;
            d1_at = cyc - base;
            d1_sh = int'(short1);
            d1_rem = int'(remain1);
            d1_s1 = int'(stock1_1);
            d1_s2 = int'(stock2_1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // One request on the main instance (optionally also the low-stock one); abort,
    // refill2 and a stray request are driven in the given cycle after accept.
    task automatic job(input logic [3:0] amt, input logic both, input int abort_at,
                       input int r2_at, input int busy_req_at, input exp_t e);
        int   rel = 0;
        int   got = 0;
        int   n2s = n2_0;
        int   n1s = n1_0;
        exp_t ex;
        q0.push_back(e);
        @(negedge clk);
        req_amount_i = amt;
        req_valid_i = 1'b1;
        v1 = both;
        @(posedge clk);
        #1;
        base = cyc - 1;
        req_valid_i = 1'b0;
        v1 = 1'b0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            @(negedge clk);
            rel = cyc - base;
            if (done_o) got = 1;
            abort_i = rel == abort_at;
            refill2_i = rel == r2_at;
            req_valid_i = rel == busy_req_at;
        end
        abort_i = 1'b0;
        refill2_i = 1'b0;
        req_valid_i = 1'b0;
        chk("done_seen", got, 1);
        ex = q0.pop_front();
        if (got != 0) begin
            chk("done_at", rel, ex.done_at);
            chk("short", short_o, ex.sh);
            chk("remain", remain_o, ex.rem);
            chk("stock1", stock1_o, ex.s1);
            chk("stock2", stock2_o, ex.s2);
            chk("out2_count", n2_0 - n2s, ex.n2);
            chk("out1_count", n1_0 - n1s, ex.n1);
        end
    endtask

    initial begin
        exp_t ex;
        int   n2s, n1s, nds;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_short", short_o, 0);
        chk("rst_remain", remain_o, 0);
        chk("rst_stock1", stock1_o, 8);
        chk("rst_stock2", stock2_o, 8);
        chk("rst_outs", {out2_o, out1_o}, 0);

        // amount 5 on both instances: greedy 2,2,1 on the main one; low stock falls short
        q1.push_back('{done_at: 10, sh: 1, rem: 2, s1: 0, s2: 0, n2: 1, n1: 1});
        job(4'd5, 1'b1, -1, -1, -1, '{done_at: 14, sh: 0, rem: 0, s1: 7, s2: 6, n2: 2, n1: 1});
        chk("t1_out2_first", p2_at[0], 2);
        chk("t1_out2_second", p2_at[1], 6);
        chk("t1_out1", p1_at[0], 10);
        ex = q1.pop_front();
        chk("low_done_seen", d1_seen, 1);
        chk("low_done_at", d1_at, ex.done_at);
        chk("low_short", d1_sh, ex.sh);
        chk("low_remain", d1_rem, ex.rem);
        chk("low_stock1", d1_s1, ex.s1);
        chk("low_stock2", d1_s2, ex.s2);
        chk("low_out2_count", n2_1, ex.n2);
        chk("low_out1_count", n1_1, ex.n1);

        job(4'd0, 1'b0, -1, -1, -1, '{done_at: 2, sh: 0, rem: 0, s1: 7, s2: 6, n2: 0, n1: 0});

        // abort in the first gap cycle after the first 2-unit pulse
        job(4'd4, 1'b0, 3, -1, -1, '{done_at: 4, sh: 1, rem: 2, s1: 7, s2: 5, n2: 1, n1: 0});
        @(negedge clk);
        chk("t4_short_held", short_o, 1);
        chk("t4_remain_held", remain_o, 2);
        chk("t4_idle", busy_o, 0);

        // refill2 coincides with the out2 pulse; a request arrives while busy
        job(4'd2, 1'b0, -1, 2, 3, '{done_at: 6, sh: 0, rem: 0, s1: 7, s2: 14, n2: 1, n1: 0});
        n2s = n2_0;
        n1s = n1_0;
        repeat (8) @(negedge clk);
        chk("t5_no_second_job", busy_o, 0);
        chk("t5_no_extra_pulses", (n2_0 - n2s) + (n1_0 - n1s), 0);

        // reset during the gap of amount 6
        n2s = n2_0;
        n1s = n1_0;
        nds = ndone0;
        @(negedge clk);
        req_amount_i = 4'd6;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        base = cyc - 1;
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_in_gap", busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_idle", busy_o, 0);
        chk("t6_stock1", stock1_o, 8);
        chk("t6_stock2", stock2_o, 8);
        chk("t6_remain", remain_o, 0);
        repeat (15) @(negedge clk);
        chk("t6_no_done", ndone0 - nds, 0);
        chk("t6_out2_only_before_rst", n2_0 - n2s, 1);
        chk("t6_no_out1", n1_0 - n1s, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
